piso_tx: RTL and testbench

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on a serial line, with a framing strobe on the last bit. It is the transmit counterpart of the lab shift-register block's serial-in/parallel-out mode, which collects bits from `data[0]`. It feeds that block's serial input, or any bit-serial consumer, in the same clock domain.

---
 rtl/piso_pkg.sv | 28 ++
 rtl/piso_tx.sv | 160 ++++++++++++++++
 tb/tb_piso_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the piso_tx serial transmitter.
//
// Contents:
//   piso_state_e : FSM state encoding (IDLE, SHIFT, PARITY). PARITY is only
//                  reachable when PISO_PARITY_EN is defined at build time.
//   cnt_width()  : width of the per-frame bit down-counter for a given word
//                  width. The counter is loaded with WIDTH-1, so $clog2(WIDTH)
//                  bits are enough.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;

  // Counter width for a WIDTH-bit word. Clamped to 1 so a degenerate width
  // never produces a zero-width vector.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : piso_pkg

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and emits it one
// bit per clock on ser_out, with ser_last marking the final bit of a frame.
//
// Build option:
//   PISO_PARITY_EN : when defined, every frame gets one extra trailing bit
//                    carrying the even parity (XOR) of the accepted word, and
//                    ser_last moves onto that parity bit. When undefined there
//                    is no parity logic and ser_last rides on the last data bit.
//
// Parameters:
//   WIDTH     : word width, legal range 2..32 (default 8)
//   MSB_FIRST : 0 sends bit 0 first, 1 sends bit WIDTH-1 first (default 0)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_valid  in   data holds a word to send
//   in_ready  out  transmitter can take a word this cycle (combinational)
//   data      in   parallel word, sampled only on acceptance
//   ser_out   out  serial data bit
//   ser_valid out  ser_out carries a valid bit this cycle
//   ser_last  out  final bit of the current frame
//   busy      out  frame in progress (same as ser_valid)
//   dbg_state out  current FSM state, for observation only
//
// Handshake: a word is transferred on a rising edge where in_valid && in_ready.
// While in_valid is high and in_ready is low the source must hold in_valid and
// data stable. in_ready is high in IDLE and in the ser_last cycle, so a word
// offered during ser_last starts the next frame with no idle gap.
//
// ser_out, ser_valid and ser_last decode only registered state; there is no
// combinational path from in_valid or data to them.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output piso_state_e      dbg_state
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  piso_state_e      state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_shift_d;
  logic [CW-1:0]    cnt_q;
  logic             cnt_zero;
  logic             last_data;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  assign cnt_zero  = (cnt_q == '0);
  assign last_data = (state_q == ST_SHIFT) && cnt_zero;

  // Shift toward the output end and zero-fill the far end.
  always_comb begin
    sr_shift_d = '0;
    if (MSB_FIRST) begin
      sr_shift_d = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      sr_shift_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // Output decode from registered state only.
  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        ser_out   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
        ser_valid = 1'b1;
`ifdef PISO_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = last_data;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        ser_out   = parity_q;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
      end
`endif
      default: begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) || ser_last;
  assign accept    = in_valid && in_ready;
  assign busy      = ser_valid;
  assign dbg_state = state_q;

  // FSM, shift register and down-counter. Acceptance can only happen in IDLE
  // or the ser_last cycle, so it takes priority over every other transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (accept) begin
      state_q  <= ST_SHIFT;
      sr_q     <= data;
      cnt_q    <= CNT_LOAD;
`ifdef PISO_PARITY_EN
      parity_q <= ^data;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_SHIFT: begin
          if (!cnt_zero) begin
            sr_q  <= sr_shift_d;
            cnt_q <= cnt_q - CW'(1);
          end else begin
`ifdef PISO_PARITY_EN
            state_q <= ST_PARITY;
`else
            state_q <= ST_IDLE;
`endif
            sr_q    <= '0;
          end
        end
        ST_PARITY: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx (WIDTH=8). Two instances share clock
// and reset: one LSB-first, one MSB-first. Frame length follows
// PISO_PARITY_EN so the same bench covers both builds.
module tb_piso_tx;
  import piso_pkg::*;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       in_valid_l = 1'b0, in_valid_m = 1'b0;
  logic [7:0] data_l = '0, data_m = '0;
  logic       rdy_l, so_l, sv_l, sl_l, busy_l;
  logic       rdy_m, so_m, sv_m, sl_m, busy_m;
  piso_state_e st_l, st_m;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(rdy_l),
    .data(data_l), .ser_out(so_l), .ser_valid(sv_l), .ser_last(sl_l),
    .busy(busy_l), .dbg_state(st_l)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(rdy_m),
    .data(data_m), .ser_out(so_m), .ser_valid(sv_m), .ser_last(sl_m),
    .busy(busy_m), .dbg_state(st_m)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector record: seq[i] is the expected ser_out in cycle i+1 of the frame.
  typedef struct {
    logic       msb;
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[9];

  // Observed outputs of the selected instance.
  task automatic sample(input logic msb, output logic so, output logic sv,
                        output logic sl, output logic rdy, output logic bz);
    so  = msb ? so_m  : so_l;
    sv  = msb ? sv_m  : sv_l;
    sl  = msb ? sl_m  : sl_l;
    rdy = msb ? rdy_m : rdy_l;
    bz  = msb ? busy_m : busy_l;
  endtask

  task automatic check_idle(input logic msb, input string tag);
    logic so, sv, sl, rdy, bz;
    sample(msb, so, sv, sl, rdy, bz);
    check1({tag, " idle ser_valid"}, sv, 1'b0);
    check1({tag, " idle ser_out"}, so, 1'b0);
    check1({tag, " idle ser_last"}, sl, 1'b0);
    check1({tag, " idle busy"}, bz, 1'b0);
    check1({tag, " idle in_ready"}, rdy, 1'b1);
  endtask

  function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int k);
    if (k <= 8) return seq[k-1];
    return par;
  endfunction

  // Called just after a negedge with the DUT idle. Offers one word for one
  // cycle, scrambles data after acceptance, checks every frame cycle.
  task automatic send_vec(input int idx);
    logic so, sv, sl, rdy, bz;
    vec_t v;
    string tag;
    v = vecs[idx];
    if (v.msb) begin in_valid_m = 1'b1; data_m = v.data; end
    else       begin in_valid_l = 1'b1; data_l = v.data; end
    @(posedge clk);
    #1;
    if (v.msb) begin in_valid_m = 1'b0; data_m = ~v.data; end
    else       begin in_valid_l = 1'b0; data_l = ~v.data; end
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      sample(v.msb, so, sv, sl, rdy, bz);
      tag = $sformatf("vec%0d cyc%0d", idx, k);
      check1({tag, " ser_valid"}, sv, 1'b1);
      check1({tag, " ser_out"}, so, exp_bit(v.seq, v.par, k));
      check1({tag, " ser_last"}, sl, (k == FL));
      check1({tag, " in_ready"}, rdy, (k == FL));
    end
    @(negedge clk);
    check_idle(v.msb, $sformatf("vec%0d post", idx));
  endtask

  // Back-to-back on the LSB instance with in_valid held across two frames.
  // With scramble set, data is changed twice during the first frame before
  // settling on d1, which must be the word taken at the ser_last cycle.
  task automatic b2b(input string name, input logic [7:0] d0, input logic [7:0] s0,
                     input logic p0, input logic [7:0] d1, input logic [7:0] s1,
                     input logic p1, input logic scramble);
    int kk;
    logic eb;
    string tag;
    in_valid_l = 1'b1;
    data_l = d0;
    @(posedge clk);
    #1;
    data_l = scramble ? 8'h66 : d1;
    for (int k = 1; k <= 2 * FL; k++) begin
      @(negedge clk);
      kk = (k <= FL) ? k : k - FL;
      eb = (k <= FL) ? exp_bit(s0, p0, kk) : exp_bit(s1, p1, kk);
      tag = $sformatf("%s cyc%0d", name, k);
      check1({tag, " ser_valid"}, sv_l, 1'b1);
      check1({tag, " ser_out"}, so_l, eb);
      check1({tag, " ser_last"}, sl_l, (kk == FL));
      check1({tag, " in_ready"}, rdy_l, (kk == FL));
      if (scramble && k == 3) data_l = 8'h99;
      if (scramble && k == 5) data_l = d1;
      if (k == FL) begin
        @(posedge clk);
        #1;
        in_valid_l = 1'b0;
        data_l = 8'h00;
      end
    end
    @(negedge clk);
    check_idle(1'b0, {name, " post"});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //        msb   data   seq    par
    vecs[0] = '{1'b0, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h01, 8'h80, 1'b1};
    vecs[2] = '{1'b0, 8'h07, 8'h07, 1'b1};
    vecs[3] = '{1'b1, 8'h07, 8'hE0, 1'b1};
    vecs[4] = '{1'b0, 8'h3C, 8'h3C, 1'b0};
    vecs[5] = '{1'b1, 8'h12, 8'h48, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h80, 8'h01, 1'b1};
    vecs[8] = '{1'b1, 8'h3C, 8'h3C, 1'b0};

    // Reset: outputs low while held, in_ready high after release.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset ser_valid lsb", sv_l, 1'b0);
    check1("reset ser_out lsb", so_l, 1'b0);
    check1("reset ser_last lsb", sl_l, 1'b0);
    check1("reset busy lsb", busy_l, 1'b0);
    check1("reset ser_valid msb", sv_m, 1'b0);
    check1("reset ser_last msb", sl_m, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "after reset lsb");
    check_idle(1'b1, "after reset msb");

    // Table-driven single frames.
    for (int i = 0; i < 9; i++) begin
      send_vec(i);
    end

    // Gapless stream: FF then 00.
    b2b("b2b", 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Data changing while held off: A5 frame intact, 3C taken at ser_last.
    b2b("holdoff", 8'hA5, 8'hA5, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1);

    // Reset in cycle 4 of a frame aborts it without ser_last.
    in_valid_l = 1'b1;
    data_l = 8'hA5;
    @(posedge clk);
    #1;
    in_valid_l = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check1($sformatf("abort cyc%0d ser_out", k), so_l, exp_bit(8'hA5, 1'b0, k));
      check1($sformatf("abort cyc%0d ser_last", k), sl_l, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check1("abort ser_valid", sv_l, 1'b0);
    check1("abort ser_out", so_l, 1'b0);
    check1("abort ser_last", sl_l, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "abort release");
    send_vec(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_piso_tx
